// File: rtl/dice_turn_ctrl.sv
// Round-robin turn scheduler sharing one electronic dice among up to four players.
// Optional build macro DICE_EXTRA_TURN_ON_SIX_EN: a non-winning 6 grants the same player another roll.
module dice_turn_ctrl #(
    parameter int N_PLAYERS = 4,
    parameter int SCORE_W   = 8,
    parameter int TARGET    = 50,
    parameter int MIN_ROLL  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_PLAYERS-1:0]           req,
    output logic                           dice_button,
    input  logic [2:0]                     dice_throw,
    output logic [1:0]                     turn,
    output logic [2:0]                     result,
    output logic                           result_valid,
    output logic                           throw_err,
    output logic [N_PLAYERS*SCORE_W-1:0]   scores,
    output logic                           winner_valid,
    output logic [1:0]                     winner
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_ROLL   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WIN    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [7:0]          roll_cnt_r, roll_cnt_s, roll_inc_s;
    logic                settle_r, settle_s;
    logic [1:0]          turn_r, turn_s;
    logic [SCORE_W-1:0]  score_r [N_PLAYERS];
    logic [SCORE_W-1:0]  score_s [N_PLAYERS];
    logic [SCORE_W-1:0]  score_sel_s, score_sum_s;
    logic [2:0]          result_r, result_s;
    logic                result_valid_r, result_valid_s;
    logic                throw_err_r, throw_err_s;
    logic                winner_valid_r, winner_valid_s;
    logic [1:0]          winner_r, winner_s;
    logic                dice_button_r, dice_button_s;
    logic [3:0]          req_pad_s;
    logic                req_own_s;

    function automatic logic throw_ok(input logic [2:0] t);
        return (t != 3'd0) && (t != 3'd7);
    endfunction

    function automatic logic [1:0] next_turn(input logic [1:0] t);
        return (t == 2'(N_PLAYERS - 1)) ? 2'd0 : t + 2'd1;
    endfunction

    assign req_pad_s = 4'(req);
    assign req_own_s = req_pad_s[turn_r];

    // Next-state and next-output logic for the turn FSM.
    always_comb begin
        state_s        = state_r;
        roll_cnt_s     = roll_cnt_r;
        settle_s       = settle_r;
        turn_s         = turn_r;
        score_s        = score_r;
        result_s       = result_r;
        result_valid_s = 1'b0;
        throw_err_s    = 1'b0;
        winner_valid_s = winner_valid_r;
        winner_s       = winner_r;
        dice_button_s  = 1'b0;

        roll_inc_s  = (roll_cnt_r >= 8'(MIN_ROLL)) ? roll_cnt_r : roll_cnt_r + 8'd1;
        score_sel_s = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            score_sel_s = (turn_r == 2'(i)) ? score_r[i] : score_sel_s;
        end
        score_sum_s = score_sel_s + SCORE_W'(dice_throw);

        case (state_r)
            ST_WAIT: begin
                if (req_own_s) begin
                    state_s       = ST_ROLL;
                    roll_cnt_s    = 8'd0;
                    dice_button_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_ROLL: begin
                // roll_inc_s counts this cycle, so the button is high exactly MIN_ROLL cycles on a short press.
                roll_cnt_s = roll_inc_s;
                if (!req_own_s && (roll_inc_s >= 8'(MIN_ROLL))) begin
                    state_s       = ST_SETTLE;
                    settle_s      = 1'b0;
                    dice_button_s = 1'b0;
                end else begin
                    dice_button_s = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!settle_r) begin
                    settle_s = 1'b1;
                end else begin
                    settle_s = 1'b0;
                    if (throw_ok(dice_throw)) begin
                        result_s       = dice_throw;
                        result_valid_s = 1'b1;
                        for (int i = 0; i < N_PLAYERS; i++) begin
                            score_s[i] = (turn_r == 2'(i)) ? score_sum_s : score_r[i];
                        end
                        if (score_sum_s >= SCORE_W'(TARGET)) begin
                            state_s        = ST_WIN;
                            winner_s       = turn_r;
                            winner_valid_s = 1'b1;
                        end else begin
                            state_s = ST_WAIT;
`ifdef DICE_EXTRA_TURN_ON_SIX_EN
                            if (dice_throw == 3'd6) begin
                                turn_s = turn_r;
                            end else begin
                                turn_s = next_turn(turn_r);
                            end
`else
                            turn_s = next_turn(turn_r);
`endif
                        end
                    end else begin
                        // Bad throw: the same player re-rolls, nothing else moves.
                        throw_err_s = 1'b1;
                        state_s     = ST_WAIT;
                    end
                end
            end
            ST_WIN: begin
                state_s = ST_WIN;
            end
            default: begin
                state_s = ST_WAIT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_WAIT;
            roll_cnt_r     <= 8'd0;
            settle_r       <= 1'b0;
            turn_r         <= 2'd0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_r[i] <= '0;
            end
            result_r       <= 3'd0;
            result_valid_r <= 1'b0;
            throw_err_r    <= 1'b0;
            winner_valid_r <= 1'b0;
            winner_r       <= 2'd0;
            dice_button_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            roll_cnt_r     <= roll_cnt_s;
            settle_r       <= settle_s;
            turn_r         <= turn_s;
            score_r        <= score_s;
            result_r       <= result_s;
            result_valid_r <= result_valid_s;
            throw_err_r    <= throw_err_s;
            winner_valid_r <= winner_valid_s;
            winner_r       <= winner_s;
            dice_button_r  <= dice_button_s;
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_scores
        assign scores[g*SCORE_W +: SCORE_W] = score_r[g];
    end

    assign dice_button  = dice_button_r;
    assign turn         = turn_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign throw_err    = throw_err_r;
    assign winner_valid = winner_valid_r;
    assign winner       = winner_r;

endmodule
